// File: rtl/axi_pcie_irq_pkg.sv
// ---------------------------------------------------------------------------
// axi_pcie_irq_pkg
// Shared types and helpers for the AXI PCIe interrupt generator:
//   - irq_state_e  : request FSM states (IDLE, REQ, GAP)
//   - MAX_VEC_LOG2 : largest MSI vector-width exponent the bridge can grant
//   - vec_mask()   : turns the bridge's MSI_Vector_Width into a vector mask
// ---------------------------------------------------------------------------
package axi_pcie_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_e;

  localparam int MAX_VEC_LOG2 = 5;

  // The bridge reports log2 of the allocated vector count. Anything above
  // 5 is clamped because MSI_Vector_Num is only 5 bits wide.
  function automatic logic [MAX_VEC_LOG2-1:0] vec_mask(input logic [2:0] width);
    logic [2:0]            w;
    logic [MAX_VEC_LOG2:0] m;
    w = (width > 3'(MAX_VEC_LOG2)) ? 3'(MAX_VEC_LOG2) : width;
    m = ((MAX_VEC_LOG2+1)'(1) << w) - (MAX_VEC_LOG2+1)'(1);
    return MAX_VEC_LOG2'(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick with a registered priority pointer.
// The first requesting channel at or after the pointer (with wrap-around)
// wins. The pointer moves only when the owner reports a completed service,
// and then points just past the serviced channel.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (pointer -> 0)
//   req_i       : per-channel request vector
//   upd_en_i    : advance pointer this cycle
//   upd_idx_i   : channel that was serviced; pointer becomes upd_idx_i + 1
//   gnt_oh_o    : one-hot winner (0 when nothing requests)
//   gnt_idx_o   : binary index of the winner
//   found_o     : at least one channel requests
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CH-1:0]                       req_i,
  input  logic                                    upd_en_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] upd_idx_i,
  output logic [NUM_CH-1:0]                       gnt_oh_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] gnt_idx_o,
  output logic                                    found_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W:0] NCH = (IDX_W+1)'(NUM_CH);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NUM_CH-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;
  logic [IDX_W:0]   nxt;

  // Rotate the request vector so the pointer position lands on bit 0; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign rot = NUM_CH'({req_i, req_i} >> ptr_q);

  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = IDX_W'(i);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NCH) begin
      sum = sum - NCH;
    end
    gnt_idx_o = sum[IDX_W-1:0];
    gnt_oh_o  = found_o ? (NUM_CH'(1) << gnt_idx_o) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    nxt   = {1'b0, upd_idx_i} + (IDX_W+1)'(1);
    if (nxt >= NCH) begin
      nxt = '0;
    end
    if (upd_en_i) begin
      ptr_d = nxt[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_pcie_irq_gen.sv
// ---------------------------------------------------------------------------
// axi_pcie_irq_gen
// Interrupt request generator for the AXI PCIe bridge. User pulses are edge
// detected into per-channel pending bits; one enabled, pending channel at a
// time is presented to the bridge on INTX_MSI_Request / MSI_Vector_Num under
// round-robin arbitration. Each request ends by grant, timeout or link loss
// and is followed by an enforced idle gap.
// Ports:
//   axi_clk_pcie, sys_reset      : clock, synchronous active-high reset
//   irq_pulse[NUM_CH]            : user requests, rising edge sets pending
//   irq_enable[NUM_CH]           : arbitration mask (pending still latches)
//   user_link_up                 : link status, gates and aborts requests
//   MSI_enable, MSI_Vector_Width : bridge MSI configuration
//   INTX_MSI_Grant               : bridge acknowledge (one cycle)
//   INTX_MSI_Request             : request to bridge
//   MSI_Vector_Num               : vector of the current request
//   irq_pending, irq_busy        : status
//   timeout_err                  : sticky timeout flag
//   grant_count, timeout_count   : wrapping statistics
// ---------------------------------------------------------------------------
module axi_pcie_irq_gen
  import axi_pcie_irq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic              axi_clk_pcie,
  input  logic              sys_reset,
  input  logic [NUM_CH-1:0] irq_pulse,
  input  logic [NUM_CH-1:0] irq_enable,
  input  logic              user_link_up,
  input  logic              MSI_enable,
  input  logic [2:0]        MSI_Vector_Width,
  input  logic              INTX_MSI_Grant,
  output logic              INTX_MSI_Request,
  output logic [4:0]        MSI_Vector_Num,
  output logic [NUM_CH-1:0] irq_pending,
  output logic              irq_busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  grant_count,
  output logic [CNT_W-1:0]  timeout_count
);

  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  // A zero-length gap still spends one cycle in GAP.
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  irq_state_e        state_q, state_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]  ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0] ch_oh_q, ch_oh_d;
  logic [4:0]        vec_q, vec_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              terr_q, terr_d;
  logic [CNT_W-1:0]  gcnt_q, gcnt_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;

  logic [NUM_CH-1:0] pend_set;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] arb_oh;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_found;
  logic              grant_hit;

  assign pend_set  = irq_pulse & ~pulse_q;
  assign eligible  = pending_q & irq_enable;
  // Grants are only meaningful while a request is outstanding.
  assign grant_hit = (state_q == REQ) && INTX_MSI_Grant;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (axi_clk_pcie),
    .reset     (sys_reset),
    .req_i     (eligible),
    .upd_en_i  (grant_hit),
    .upd_idx_i (ch_idx_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .found_o   (arb_found)
  );

  always_comb begin
    state_d   = state_q;
    pulse_d   = irq_pulse;
    pending_d = pending_q | pend_set;
    ch_idx_d  = ch_idx_q;
    ch_oh_d   = ch_oh_q;
    vec_d     = vec_q;
    req_d     = req_q;
    tmr_d     = tmr_q;
    terr_d    = terr_q;
    gcnt_d    = gcnt_q;
    tcnt_d    = tcnt_q;

    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        tmr_d = '0;
        if (user_link_up && arb_found) begin
          state_d  = REQ;
          req_d    = 1'b1;
          ch_idx_d = arb_idx;
          ch_oh_d  = arb_oh;
          vec_d    = MSI_enable ? (5'(arb_idx) & vec_mask(MSI_Vector_Width)) : 5'd0;
        end
      end

      REQ: begin
        if (grant_hit) begin
          // A fresh edge on the serviced channel in the grant cycle survives.
          pending_d = (pending_q & ~ch_oh_q) | pend_set;
          gcnt_d    = gcnt_q + CNT_W'(1);
          req_d     = 1'b0;
          tmr_d     = '0;
          state_d   = GAP;
        end else if (!user_link_up) begin
          req_d   = 1'b0;
          tmr_d   = '0;
          state_d = GAP;
        end else if (tmr_q == TO_LAST) begin
          terr_d  = 1'b1;
          tcnt_d  = tcnt_q + CNT_W'(1);
          req_d   = 1'b0;
          tmr_d   = '0;
          state_d = GAP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      GAP: begin
        req_d = 1'b0;
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: begin
        req_d   = 1'b0;
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge axi_clk_pcie) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      pulse_q   <= '0;
      pending_q <= '0;
      ch_idx_q  <= '0;
      ch_oh_q   <= '0;
      vec_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      tmr_q     <= '0;
      terr_q    <= 1'b0;
      gcnt_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      ch_idx_q  <= ch_idx_d;
      ch_oh_q   <= ch_oh_d;
      vec_q     <= vec_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      tmr_q     <= tmr_d;
      terr_q    <= terr_d;
      gcnt_q    <= gcnt_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign INTX_MSI_Request = req_q;
  assign MSI_Vector_Num   = vec_q;
  assign irq_pending      = pending_q;
  assign irq_busy         = busy_q;
  assign timeout_err      = terr_q;
  assign grant_count      = gcnt_q;
  assign timeout_count    = tcnt_q;

endmodule

// File: tb/tb_axi_pcie_irq_gen.sv
// ---------------------------------------------------------------------------
// tb_axi_pcie_irq_gen
// Directed bench for axi_pcie_irq_gen (NUM_CH=4, GAP=16, TIMEOUT=8).
// The stimulus process queues the vector each upcoming request must carry;
// an independent monitor pops one entry on every rising edge of
// INTX_MSI_Request and checks the vector for the life of the request.
// ---------------------------------------------------------------------------
module tb_axi_pcie_irq_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic              axi_clk_pcie = 1'b0;
  logic              sys_reset;
  logic [NUM_CH-1:0] irq_pulse;
  logic [NUM_CH-1:0] irq_enable;
  logic              user_link_up;
  logic              MSI_enable;
  logic [2:0]        MSI_Vector_Width;
  logic              INTX_MSI_Grant;
  logic              INTX_MSI_Request;
  logic [4:0]        MSI_Vector_Num;
  logic [NUM_CH-1:0] irq_pending;
  logic              irq_busy;
  logic              timeout_err;
  logic [CNT_W-1:0]  grant_count;
  logic [CNT_W-1:0]  timeout_count;

  int checks = 0;
  int errors = 0;
  logic [4:0] expQ[$];

  always #5 axi_clk_pcie = ~axi_clk_pcie;

  axi_pcie_irq_gen #(
    .NUM_CH         (NUM_CH),
    .GAP_CYCLES     (16),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (CNT_W)
  ) dut (
    .axi_clk_pcie     (axi_clk_pcie),
    .sys_reset        (sys_reset),
    .irq_pulse        (irq_pulse),
    .irq_enable       (irq_enable),
    .user_link_up     (user_link_up),
    .MSI_enable       (MSI_enable),
    .MSI_Vector_Width (MSI_Vector_Width),
    .INTX_MSI_Grant   (INTX_MSI_Grant),
    .INTX_MSI_Request (INTX_MSI_Request),
    .MSI_Vector_Num   (MSI_Vector_Num),
    .irq_pending      (irq_pending),
    .irq_busy         (irq_busy),
    .timeout_err      (timeout_err),
    .grant_count      (grant_count),
    .timeout_count    (timeout_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge axi_clk_pcie);
  endtask

  // One-cycle pulse on the selected channels.
  task automatic applyStimulus(input logic [NUM_CH-1:0] mask);
    irq_pulse = mask;
    @(negedge axi_clk_pcie);
    irq_pulse = '0;
  endtask

  task automatic doGrant();
    INTX_MSI_Grant = 1'b1;
    @(negedge axi_clk_pcie);
    INTX_MSI_Grant = 1'b0;
  endtask

  // Returns the number of low cycles observed before the request appeared.
  task automatic waitReq(input string name, input int budget, output int lows);
    lows = 0;
    while (!INTX_MSI_Request && lows < budget) begin
      lows++;
      @(negedge axi_clk_pcie);
    end
    checks++;
    if (!INTX_MSI_Request) begin
      errors++;
      $display("[TB] FAIL %s: request got 0 expected 1 within %0d cycles", name, budget);
    end
  endtask

  initial begin : monitor
    logic       prevReq;
    logic [4:0] curExp;
    prevReq = 1'b0;
    curExp  = '0;
    forever begin
      @(negedge axi_clk_pcie);
      if (INTX_MSI_Request && !prevReq) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_request: got request with vector %0h, expected none",
                   MSI_Vector_Num);
        end else begin
          curExp = expQ.pop_front();
          checkOutput("req_vector", 32'(MSI_Vector_Num), 32'(curExp));
        end
      end else if (INTX_MSI_Request && prevReq) begin
        checkOutput("vector_stable", 32'(MSI_Vector_Num), 32'(curExp));
      end
      prevReq = INTX_MSI_Request;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation got stuck, expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int lows;
    int hi;
    logic [NUM_CH-1:0] expPend;

    sys_reset        = 1'b1;
    irq_pulse        = '0;
    irq_enable       = '0;
    user_link_up     = 1'b0;
    MSI_enable       = 1'b0;
    MSI_Vector_Width = 3'd0;
    INTX_MSI_Grant   = 1'b0;
    tick(3);

    // Reset state
    checkOutput("rst_request", 32'(INTX_MSI_Request), 0);
    checkOutput("rst_vector", 32'(MSI_Vector_Num), 0);
    checkOutput("rst_pending", 32'(irq_pending), 0);
    checkOutput("rst_busy", 32'(irq_busy), 0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 0);
    checkOutput("rst_grant_count", grant_count, 0);
    checkOutput("rst_timeout_count", timeout_count, 0);
    sys_reset = 1'b0;
    tick(1);

    // Single MSI on channel 3, width 2
    $display("[TB] single MSI");
    user_link_up     = 1'b1;
    MSI_enable       = 1'b1;
    MSI_Vector_Width = 3'd2;
    irq_enable       = 4'hF;
    tick(1);
    expQ.push_back(5'd3);
    applyStimulus(4'b1000);
    checkOutput("lat_cycle1_request", 32'(INTX_MSI_Request), 0);
    checkOutput("lat_cycle1_pending", 32'(irq_pending), 32'h8);
    tick(1);
    checkOutput("lat_cycle2_request", 32'(INTX_MSI_Request), 1);
    tick(4);
    doGrant();
    checkOutput("single_req_drop", 32'(INTX_MSI_Request), 0);
    checkOutput("single_grant_count", grant_count, 1);
    checkOutput("single_pending", 32'(irq_pending), 0);
    checkOutput("single_busy_gap", 32'(irq_busy), 1);
    tick(20);
    checkOutput("single_busy_idle", 32'(irq_busy), 0);

    // Round robin with vector fold, width 1
    $display("[TB] round robin");
    MSI_Vector_Width = 3'd1;
    expQ.push_back(5'd0);
    expQ.push_back(5'd1);
    expQ.push_back(5'd0);
    expQ.push_back(5'd1);
    applyStimulus(4'b1111);
    for (int k = 0; k < 4; k++) begin
      waitReq("rr_request", 40, lows);
      if (k > 0) begin
        checkOutput("rr_gap_in_range", 32'(lows >= 16 && lows <= 17), 1);
      end
      doGrant();
      expPend = 4'hF << (k + 1);
      checkOutput("rr_pending", 32'(irq_pending), 32'(expPend));
    end
    checkOutput("rr_grant_count", grant_count, 5);
    tick(20);

    // Timeout and retry on channel 1, width 2
    $display("[TB] timeout retry");
    MSI_Vector_Width = 3'd2;
    expQ.push_back(5'd1);
    expQ.push_back(5'd1);
    applyStimulus(4'b0010);
    waitReq("to_request", 10, lows);
    hi = 0;
    while (INTX_MSI_Request && hi < 20) begin
      hi++;
      @(negedge axi_clk_pcie);
    end
    checkOutput("to_request_len", 32'(hi), 8);
    checkOutput("to_err", 32'(timeout_err), 1);
    checkOutput("to_count", timeout_count, 1);
    checkOutput("to_pending_kept", 32'(irq_pending), 32'h2);
    checkOutput("to_grant_count", grant_count, 5);
    waitReq("to_retry", 40, lows);
    checkOutput("to_retry_gap", 32'(lows >= 16 && lows <= 17), 1);
    doGrant();
    checkOutput("to_retry_grant_count", grant_count, 6);
    checkOutput("to_retry_pending", 32'(irq_pending), 0);
    checkOutput("to_count_after", timeout_count, 1);
    tick(20);

    // Link gating
    $display("[TB] link gating and masking");
    user_link_up = 1'b0;
    applyStimulus(4'b0010);
    tick(5);
    checkOutput("link_down_request", 32'(INTX_MSI_Request), 0);
    checkOutput("link_down_pending", 32'(irq_pending), 32'h2);
    checkOutput("link_down_busy", 32'(irq_busy), 0);
    expQ.push_back(5'd1);
    user_link_up = 1'b1;
    waitReq("link_up_request", 10, lows);
    doGrant();
    checkOutput("link_up_pending", 32'(irq_pending), 0);
    checkOutput("link_up_grant_count", grant_count, 7);
    tick(20);

    // Masking channel 2
    irq_enable = 4'b1011;
    applyStimulus(4'b0100);
    tick(30);
    checkOutput("mask_pending", 32'(irq_pending), 32'h4);
    checkOutput("mask_busy", 32'(irq_busy), 0);
    expQ.push_back(5'd2);
    irq_enable = 4'hF;
    waitReq("unmask_request", 10, lows);
    doGrant();
    checkOutput("unmask_pending", 32'(irq_pending), 0);
    checkOutput("unmask_grant_count", grant_count, 8);
    tick(20);

    // Coalescing repeated pulses on channel 0
    $display("[TB] coalesce and same-cycle set");
    expQ.push_back(5'd0);
    applyStimulus(4'b0001);
    tick(1);
    applyStimulus(4'b0001);
    tick(1);
    applyStimulus(4'b0001);
    waitReq("coal_request", 10, lows);
    doGrant();
    checkOutput("coal_pending", 32'(irq_pending), 0);
    checkOutput("coal_grant_count", grant_count, 9);
    tick(25);
    checkOutput("coal_no_second_req", 32'(INTX_MSI_Request), 0);
    checkOutput("coal_busy", 32'(irq_busy), 0);

    // Edge in the grant cycle keeps the bit pending
    expQ.push_back(5'd0);
    expQ.push_back(5'd0);
    applyStimulus(4'b0001);
    waitReq("same_request", 10, lows);
    irq_pulse      = 4'b0001;
    INTX_MSI_Grant = 1'b1;
    @(negedge axi_clk_pcie);
    irq_pulse      = '0;
    INTX_MSI_Grant = 1'b0;
    checkOutput("same_pending_kept", 32'(irq_pending), 32'h1);
    checkOutput("same_req_drop", 32'(INTX_MSI_Request), 0);
    checkOutput("same_grant_count", grant_count, 10);
    waitReq("same_second_request", 40, lows);
    doGrant();
    checkOutput("same_second_pending", 32'(irq_pending), 0);
    checkOutput("same_second_grant_count", grant_count, 11);
    tick(20);

    // Reset in the middle of a request
    $display("[TB] reset mid-request");
    expQ.push_back(5'd1);
    applyStimulus(4'b0010);
    waitReq("rstmid_request", 10, lows);
    tick(1);
    sys_reset = 1'b1;
    @(negedge axi_clk_pcie);
    checkOutput("rstmid_request", 32'(INTX_MSI_Request), 0);
    checkOutput("rstmid_pending", 32'(irq_pending), 0);
    checkOutput("rstmid_grant_count", grant_count, 0);
    checkOutput("rstmid_timeout_count", timeout_count, 0);
    checkOutput("rstmid_timeout_err", 32'(timeout_err), 0);
    checkOutput("rstmid_busy", 32'(irq_busy), 0);
    sys_reset      = 1'b0;
    INTX_MSI_Grant = 1'b1;
    @(negedge axi_clk_pcie);
    INTX_MSI_Grant = 1'b0;
    tick(2);
    checkOutput("stray_grant_count", grant_count, 0);
    checkOutput("stray_request", 32'(INTX_MSI_Request), 0);
    tick(5);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
